// File: rtl/cpu_ctrl.sv
// cpu_ctrl: multi-cycle controller for the 4-entry, 2-read/1-write register file.
// It accepts one instruction per handshake and sequences reads, ALU evaluation
// and write-back through a Moore FSM (IDLE -> READ -> EXEC -> WRITE).
module cpu_ctrl #(
  parameter int REG_WID = 10
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               instr_valid_i,
  output logic               instr_ready_o,
  input  logic [7:0]         instr_i,
  input  logic [REG_WID-1:0] imm_i,
  output logic               done_o,
  output logic               zero_o,
  output logic               carry_o,
  output logic               rd_A_en_o,
  output logic               rd_B_en_o,
  output logic [1:0]         rd_A_addr_o,
  output logic [1:0]         rd_B_addr_o,
  input  logic [REG_WID-1:0] data_A_i,
  input  logic [REG_WID-1:0] data_B_i,
  output logic               wr_en_o,
  output logic [1:0]         wr_addr_o,
  output logic [REG_WID-1:0] data_RF_o
);

  typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

  localparam logic [1:0] OP_LDI = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_MOV = 2'b11;

  state_t             state_reg, state_next;
  logic [7:0]         instr_reg, instr_next;
  logic [REG_WID-1:0] result_reg, result_next;
  logic [1:0]         wr_addr_reg, wr_addr_next;
  logic               zero_reg, zero_next;
  logic               carry_reg, carry_next;

  logic [1:0]         op_q;
  logic [REG_WID:0]   sum_ext;
  logic [REG_WID:0]   diff_ext;

  // One extra bit holds the carry of ADD and the borrow of SUB.
  assign op_q     = instr_reg[7:6];
  assign sum_ext  = {1'b0, data_A_i} + {1'b0, data_B_i};
  assign diff_ext = {1'b0, data_A_i} - {1'b0, data_B_i};

  // Read addresses come straight from the latched instruction so they stay
  // stable for the whole instruction; write address/data hold between writes.
  assign rd_A_addr_o = instr_reg[3:2];
  assign rd_B_addr_o = instr_reg[1:0];
  assign wr_addr_o   = wr_addr_reg;
  assign data_RF_o   = result_reg;
  assign zero_o      = zero_reg;
  assign carry_o     = carry_reg;

  // State and datapath registers; an asynchronous reset abandons any instruction.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= IDLE;
      instr_reg   <= '0;
      result_reg  <= '0;
      wr_addr_reg <= '0;
      zero_reg    <= 1'b0;
      carry_reg   <= 1'b0;
    end else begin
      state_reg   <= state_next;
      instr_reg   <= instr_next;
      result_reg  <= result_next;
      wr_addr_reg <= wr_addr_next;
      zero_reg    <= zero_next;
      carry_reg   <= carry_next;
    end
  end

  // Next-state, datapath updates and Moore control outputs decoded from state.
  always_comb begin
    state_next    = state_reg;
    instr_next    = instr_reg;
    result_next   = result_reg;
    wr_addr_next  = wr_addr_reg;
    zero_next     = zero_reg;
    carry_next    = carry_reg;
    instr_ready_o = 1'b0;
    rd_A_en_o     = 1'b0;
    rd_B_en_o     = 1'b0;
    wr_en_o       = 1'b0;
    done_o        = 1'b0;

    case (state_reg)
      IDLE: begin
        instr_ready_o = 1'b1;
        if (instr_valid_i) begin
          instr_next = instr_i;
          if (instr_i[7:6] == OP_LDI) begin
            // LDI skips the register file: the immediate is the result.
            result_next  = imm_i;
            wr_addr_next = instr_i[5:4];
            state_next   = WRITE;
          end else begin
            state_next = READ;
          end
        end
      end
      READ: begin
        rd_A_en_o  = 1'b1;
        rd_B_en_o  = (op_q == OP_ADD) || (op_q == OP_SUB);
        state_next = EXEC;
      end
      EXEC: begin
        case (op_q)
          OP_ADD: begin
            result_next = sum_ext[REG_WID-1:0];
            carry_next  = sum_ext[REG_WID];
            zero_next   = (sum_ext[REG_WID-1:0] == '0);
          end
          OP_SUB: begin
            result_next = diff_ext[REG_WID-1:0];
            carry_next  = diff_ext[REG_WID];
            zero_next   = (diff_ext[REG_WID-1:0] == '0);
          end
          OP_MOV: begin
            result_next = data_A_i;
          end
          default: begin
          end
        endcase
        wr_addr_next = instr_reg[5:4];
        state_next   = WRITE;
      end
      WRITE: begin
        wr_en_o    = 1'b1;
        done_o     = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_cpu_ctrl.sv
// Scoreboard bench for cpu_ctrl: a driver predicts each instruction's
// architectural effect on acceptance; a monitor checks reads and write-backs.
module tb_cpu_ctrl;

  localparam int W   = 10;
  localparam int MOD = 1 << W;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         instr_valid_i;
  logic         instr_ready_o;
  logic [7:0]   instr_i;
  logic [W-1:0] imm_i;
  logic         done_o, zero_o, carry_o;
  logic         rd_A_en_o, rd_B_en_o;
  logic [1:0]   rd_A_addr_o, rd_B_addr_o;
  logic [W-1:0] data_A, data_B;
  logic         wr_en_o;
  logic [1:0]   wr_addr_o;
  logic [W-1:0] data_RF_o;

  always #5 clk = ~clk;

  cpu_ctrl #(.REG_WID(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .instr_valid_i(instr_valid_i), .instr_ready_o(instr_ready_o),
    .instr_i(instr_i), .imm_i(imm_i),
    .done_o(done_o), .zero_o(zero_o), .carry_o(carry_o),
    .rd_A_en_o(rd_A_en_o), .rd_B_en_o(rd_B_en_o),
    .rd_A_addr_o(rd_A_addr_o), .rd_B_addr_o(rd_B_addr_o),
    .data_A_i(data_A), .data_B_i(data_B),
    .wr_en_o(wr_en_o), .wr_addr_o(wr_addr_o), .data_RF_o(data_RF_o)
  );

  // Register file attached to the controller (not reset, one-cycle read).
  logic [W-1:0] rf [4];
  always @(posedge clk) begin
    if (wr_en_o)   rf[wr_addr_o]  <= data_RF_o;
    if (rd_A_en_o) data_A <= rf[rd_A_addr_o];
    if (rd_B_en_o) data_B <= rf[rd_B_addr_o];
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [1:0]   rd;
    logic [W-1:0] data;
    logic         z, c;
    logic [1:0]   ra, rb;
    bit           use_a, use_b, read_seen;
    int           rd_cyc, wr_cyc;
  } exp_t;

  exp_t         sb[$];
  int           checks = 0;
  int           failures = 0;
  logic [W-1:0] rf_m [4];
  logic         zero_m = 1'b0;
  logic         carry_m = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Architectural model: registers and flags updated by plain integer math.
  task automatic predict(input logic [7:0] ins, input logic [W-1:0] imm, input int acc);
    exp_t e;
    int   a, b, r;
    a = int'(rf_m[ins[3:2]]);
    b = int'(rf_m[ins[1:0]]);
    e.rd = ins[5:4]; e.ra = ins[3:2]; e.rb = ins[1:0];
    e.read_seen = 1'b0;
    e.use_a = (ins[7:6] != 2'b00);
    e.use_b = (ins[7:6] == 2'b01) || (ins[7:6] == 2'b10);
    e.rd_cyc = acc + 1;
    e.wr_cyc = e.use_a ? acc + 3 : acc + 1;
    case (ins[7:6])
      2'b00: r = int'(imm);
      2'b01: begin r = (a + b) % MOD; carry_m = (a + b) >= MOD; zero_m = (r == 0); end
      2'b10: begin r = (a - b + MOD) % MOD; carry_m = (a < b); zero_m = (r == 0); end
      default: r = a;
    endcase
    rf_m[ins[5:4]] = r[W-1:0];
    e.data = r[W-1:0];
    e.z = zero_m;
    e.c = carry_m;
    sb.push_back(e);
    $display("issue op=%0d rd=%0d ra=%0d rb=%0d imm=%0d -> expect data=%0d z=%0d c=%0d",
             ins[7:6], ins[5:4], ins[3:2], ins[1:0], imm, e.data, e.z, e.c);
  endtask

  // Called at a falling edge; returns at the falling edge after acceptance.
  task automatic issue(input logic [7:0] ins, input logic [W-1:0] imm);
    instr_valid_i = 1'b1;
    instr_i = ins;
    imm_i = imm;
    for (int k = 0; k < 16; k++) begin
      if (instr_ready_o) begin
        predict(ins, imm, cyc);
        @(negedge clk);
        instr_valid_i = 1'b0;
        return;
      end
      @(negedge clk);
    end
    chk("accept_timeout", 32'(instr_ready_o), 1);
    instr_valid_i = 1'b0;
  endtask

  task automatic check_reset_outs();
    chk("rst_ready",  32'(instr_ready_o), 1);
    chk("rst_done",   32'(done_o), 0);
    chk("rst_wr_en",  32'(wr_en_o), 0);
    chk("rst_rdA_en", 32'(rd_A_en_o), 0);
    chk("rst_rdB_en", 32'(rd_B_en_o), 0);
    chk("rst_zero",   32'(zero_o), 0);
    chk("rst_carry",  32'(carry_o), 0);
    chk("rst_rdA_ad", 32'(rd_A_addr_o), 0);
    chk("rst_rdB_ad", 32'(rd_B_addr_o), 0);
    chk("rst_wr_ad",  32'(wr_addr_o), 0);
    chk("rst_data",   32'(data_RF_o), 0);
  endtask

  // Monitor: checks register-file reads and pops one expectation per write-back.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (rd_B_en_o && !rd_A_en_o) chk("rdB_without_rdA", 32'(rd_A_en_o), 1);
      if (wr_en_o || done_o) chk("wr_en_vs_done", 32'(wr_en_o), 32'(done_o));
      if (rd_A_en_o) begin
        chk("read_has_instr", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          chk("read_expected", 32'(sb[0].use_a), 1);
          chk("read_cycle", 32'(cyc), 32'(sb[0].rd_cyc));
          chk("rdA_addr", 32'(rd_A_addr_o), 32'(sb[0].ra));
          chk("rdB_en", 32'(rd_B_en_o), 32'(sb[0].use_b));
          if (sb[0].use_b) chk("rdB_addr", 32'(rd_B_addr_o), 32'(sb[0].rb));
          sb[0].read_seen = 1'b1;
        end
      end
      if (done_o) begin
        chk("done_has_instr", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          exp_t e;
          e = sb.pop_front();
          chk("done_cycle", 32'(cyc), 32'(e.wr_cyc));
          chk("wr_addr", 32'(wr_addr_o), 32'(e.rd));
          chk("wr_data", 32'(data_RF_o), 32'(e.data));
          chk("zero", 32'(zero_o), 32'(e.z));
          chk("carry", 32'(carry_o), 32'(e.c));
          if (e.use_a) chk("read_before_write", 32'(e.read_seen), 1);
          $display("writeback r%0d=%0d z=%0d c=%0d", wr_addr_o, data_RF_o, zero_o, carry_o);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [1:0]   op;
    logic [W-1:0] imm;
    rst_n = 1'b0;
    instr_valid_i = 1'b0;
    instr_i = '0;
    imm_i = '0;
    repeat (3) @(negedge clk);
    check_reset_outs();
    rst_n = 1'b1;
    @(negedge clk);

    // Loads back-to-back, ADD, SUB with borrow.
    issue({2'b00, 2'd0, 4'd0}, W'(5));
    issue({2'b00, 2'd1, 4'd0}, W'(3));
    issue({2'b01, 2'd2, 2'd0, 2'd1}, '0);
    issue({2'b10, 2'd3, 2'd1, 2'd0}, '0);

    // Wrap to zero, then MOV keeps flags and reads only port A.
    issue({2'b00, 2'd0, 4'd0}, W'(MOD - 1));
    issue({2'b00, 2'd1, 4'd0}, W'(1));
    issue({2'b01, 2'd2, 2'd0, 2'd1}, '0);
    issue({2'b11, 2'd3, 2'd1, 2'd0}, '0);
    chk("mov_keeps_zero", 32'(zero_o), 1);
    chk("mov_keeps_carry", 32'(carry_o), 1);
    repeat (3) @(negedge clk);

    // Handshake: a different instruction offered while busy is ignored.
    issue({2'b01, 2'd2, 2'd0, 2'd1}, '0);
    instr_valid_i = 1'b1;
    instr_i = {2'b00, 2'd3, 4'd0};
    imm_i = W'(99);
    chk("busy_not_ready_read", 32'(instr_ready_o), 0);
    @(negedge clk);
    chk("busy_not_ready_exec", 32'(instr_ready_o), 0);
    instr_valid_i = 1'b0;
    repeat (4) @(negedge clk);

    // Reset during EXEC: instruction abandoned, target keeps its old value.
    issue({2'b00, 2'd2, 4'd0}, W'(77));
    issue({2'b01, 2'd2, 2'd0, 2'd1}, '0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_reset_outs();
    sb.delete();
    rf_m[2] = W'(77);
    zero_m = 1'b0;
    carry_m = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    issue({2'b11, 2'd3, 2'd2, 2'd0}, '0);

    // Randomized stream with random idle gaps.
    for (int i = 0; i < 300; i++) begin
      op = 2'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
        0: imm = '0;
        1: imm = W'(MOD - 1);
        2: imm = W'(1);
        default: imm = W'($urandom_range(0, MOD - 1));
      endcase
      issue({op, 6'($urandom_range(0, 63))}, imm);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    for (int k = 0; k < 20 && sb.size() != 0; k++) @(negedge clk);
    chk("scoreboard_drained", 32'(sb.size()), 0);
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
